// File: rtl/uart_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : uart_pkg
//  Brief    : Shared constants and FSM encoding for the MiniUART TX feeder
//  Revision : 1.0 - initial release
// ============================================================================
package uart_pkg;

   // FIFO geometry defaults
   localparam int          UART_FIFO_DEPTH    = 16;
   localparam int          UART_FIFO_AW       = 4;

   // MiniUART register word offsets (off[4:2])
   localparam logic [2:0]  UART_OFF_DATA      = 3'd0;
   localparam logic [2:0]  UART_OFF_LSR       = 3'd1;
   localparam logic [2:0]  UART_OFF_DIVT      = 3'd4;

   // Transmit divisor for 9600 baud
   localparam logic [31:0] UART_BAUD_SND_9600 = 32'd9;

   // LSR bit that reports "transmitter ready"
   localparam int          UART_THRE_BIT      = 5;

   // Feeder FSM encoding
   typedef enum logic [2:0] {
      ST_INIT_DIV = 3'd0,
      ST_IDLE     = 3'd1,
      ST_POLL     = 3'd2,
      ST_SEND     = 3'd3,
      ST_GAP      = 3'd4
   } state_t;

endpackage
`default_nettype wire

// File: rtl/uart_tx_feeder_if.sv
`default_nettype none
// ============================================================================
//  Module   : uart_tx_feeder_if
//  Brief    : Producer push port plus WISHBONE master port of the TX feeder
//  Revision : 1.0 - initial release
// ============================================================================
interface uart_tx_feeder_if #(
   parameter int AW = 4
);
   // producer side
   logic          push_valid;
   logic [7:0]    push_data;
   logic          push_ready;
   logic          overflow;
   logic [AW:0]   fifo_count;
   logic          busy;
   // WISHBONE side towards the MiniUART
   logic [2:0]    wb_off;
   logic [31:0]   wb_dout;
   logic [31:0]   wb_din;
   logic          wb_stb;
   logic          wb_we;
   logic          wb_ack;

   // the feeder: bus master, push-port consumer
   modport master (
      input  push_valid, push_data, wb_din, wb_ack,
      output push_ready, overflow, fifo_count, busy,
      output wb_off, wb_dout, wb_stb, wb_we
   );

   // the environment: producer plus MiniUART register slave
   modport slave (
      output push_valid, push_data, wb_din, wb_ack,
      input  push_ready, overflow, fifo_count, busy,
      input  wb_off, wb_dout, wb_stb, wb_we
   );
endinterface
`default_nettype wire

// File: rtl/uart_tx_fifo.sv
`default_nettype none
// ============================================================================
//  Module   : uart_tx_fifo
//  Brief    : Byte FIFO buffering producer data ahead of the MiniUART
//  Revision : 1.0 - initial release
// ============================================================================
module uart_tx_fifo #(
   parameter int DEPTH = 16,
   parameter int AW    = 4
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          push,
   input  logic [7:0]    push_data,
   input  logic          pop,
   output logic [7:0]    head,
   output logic [AW:0]   count,
   output logic          full,
   output logic          empty
);
   localparam logic [AW:0] c_full_count = (AW+1)'(DEPTH);

   logic [7:0]    r_mem [DEPTH];
   logic [AW-1:0] r_wr_ptr;
   logic [AW-1:0] r_rd_ptr;
   logic [AW:0]   r_count;
   logic          w_do_push;
   logic          w_do_pop;

   // Overfull pushes and empty pops are discarded here as a safety net
   assign w_do_push = push & ~full;
   assign w_do_pop  = pop & ~empty;

   assign full  = (r_count == c_full_count);
   assign empty = (r_count == '0);
   assign count = r_count;
   assign head  = r_mem[r_rd_ptr];

   // Storage array; contents need no reset since count gates visibility
   always_ff @(posedge clk) begin
      if (w_do_push) r_mem[r_wr_ptr] <= push_data;
   end

   // Pointers wrap naturally because DEPTH is a power of two
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
         if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
         case ({w_do_push, w_do_pop})
            2'b10:   r_count <= r_count + 1'b1;
            2'b01:   r_count <= r_count - 1'b1;
            default: r_count <= r_count;
         endcase
      end
   end
endmodule
`default_nettype wire

// File: rtl/uart_tx_feeder.sv
`default_nettype none
// ============================================================================
//  Module   : uart_tx_feeder
//  Brief    : Drains a byte FIFO into the MiniUART over WISHBONE: writes the
//             divisor once after reset, then polls LSR and writes DATA.
//  Revision : 1.0 - initial release
// ============================================================================
module uart_tx_feeder
   import uart_pkg::*;
#(
   parameter int          DEPTH     = UART_FIFO_DEPTH,
   parameter int          AW        = UART_FIFO_AW,
   parameter logic [2:0]  OFF_DATA  = UART_OFF_DATA,
   parameter logic [2:0]  OFF_LSR   = UART_OFF_LSR,
   parameter logic [2:0]  OFF_DIVT  = UART_OFF_DIVT,
   parameter logic [31:0] DIVT_INIT = UART_BAUD_SND_9600,
   parameter int          THRE_BIT  = UART_THRE_BIT
) (
   input  logic               clk,
   input  logic               rst,
   uart_tx_feeder_if.master   bus
);
   state_t        r_state, w_next;
   state_t        r_gap_next, w_gap_next;
   logic          r_stb, r_we, w_stb, w_we;
   logic [2:0]    r_off, w_off;
   logic [31:0]   r_dout, w_dout;
   logic          r_overflow;
   logic          w_ack, w_push, w_pop;
   logic [7:0]    w_head;
   logic [AW:0]   w_count;
   logic          w_full, w_empty;

   // An ack only counts while our strobe is actually up
   assign w_ack  = r_stb & bus.wb_ack;
   assign w_push = bus.push_valid & ~w_full;
   assign w_pop  = (r_state == ST_SEND) & w_ack;

   uart_tx_fifo #(.DEPTH(DEPTH), .AW(AW)) u_fifo (
      .clk       (clk),
      .rst       (rst),
      .push      (w_push),
      .push_data (bus.push_data),
      .pop       (w_pop),
      .head      (w_head),
      .count     (w_count),
      .full      (w_full),
      .empty     (w_empty)
   );

   // State register; GAP remembers where to go after its idle cycle
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state    <= ST_INIT_DIV;
         r_gap_next <= ST_IDLE;
      end else begin
         r_state    <= w_next;
         r_gap_next <= w_gap_next;
      end
   end

   // Next-state logic: every completed transaction passes through GAP
   always_comb begin
      w_next     = r_state;
      w_gap_next = r_gap_next;
      case (r_state)
         ST_INIT_DIV: if (w_ack) begin
            w_next     = ST_GAP;
            w_gap_next = ST_IDLE;
         end
         ST_IDLE:     if (!w_empty) w_next = ST_POLL;
         ST_POLL:     if (w_ack) begin
            w_next     = ST_GAP;
            w_gap_next = bus.wb_din[THRE_BIT] ? ST_SEND : ST_POLL;
         end
         ST_SEND:     if (w_ack) begin
            w_next     = ST_GAP;
            w_gap_next = ST_IDLE;
         end
         ST_GAP:      w_next = r_gap_next;
         default:     w_next = ST_INIT_DIV;
      endcase
   end

   // Output decode from the upcoming state so the registered outputs line up
   always_comb begin
      w_stb  = 1'b0;
      w_we   = 1'b0;
      w_off  = 3'd0;
      w_dout = 32'd0;
      case (w_next)
         ST_INIT_DIV: begin
            w_stb  = 1'b1;
            w_we   = 1'b1;
            w_off  = OFF_DIVT;
            w_dout = DIVT_INIT;
         end
         ST_POLL: begin
            w_stb  = 1'b1;
            w_off  = OFF_LSR;
         end
         ST_SEND: begin
            w_stb  = 1'b1;
            w_we   = 1'b1;
            w_off  = OFF_DATA;
            w_dout = {24'd0, w_head};
         end
         default: ;
      endcase
   end

   // Master output registers; reset drops the strobe immediately
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_stb  <= 1'b0;
         r_we   <= 1'b0;
         r_off  <= 3'd0;
         r_dout <= 32'd0;
      end else begin
         r_stb  <= w_stb;
         r_we   <= w_we;
         r_off  <= w_off;
         r_dout <= w_dout;
      end
   end

   // Sticky overflow flag for pushes offered while the FIFO is full
   always_ff @(posedge clk or posedge rst) begin
      if (rst) r_overflow <= 1'b0;
      else     r_overflow <= r_overflow | (bus.push_valid & w_full);
   end

   assign bus.wb_stb     = r_stb;
   assign bus.wb_we      = r_we;
   assign bus.wb_off     = r_off;
   assign bus.wb_dout    = r_dout;
   assign bus.push_ready = ~w_full;
   assign bus.overflow   = r_overflow;
   assign bus.fifo_count = w_count;
   assign bus.busy       = (r_state != ST_IDLE) | ~w_empty;
endmodule
`default_nettype wire

// File: tb/tb_uart_tx_feeder.sv
`default_nettype none
// ============================================================================
//  Module   : tb_uart_tx_feeder
//  Brief    : Self-checking bench: MiniUART register slave model plus a
//             write scoreboard fed by the producer stimulus
//  Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_uart_tx_feeder;
   import uart_pkg::*;

   localparam int DEPTH = 16;
   localparam int AW    = 4;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   uart_tx_feeder_if #(.AW(AW)) bus ();

   uart_tx_feeder #(.DEPTH(DEPTH), .AW(AW)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   int          n_checks = 0;
   int          n_errors = 0;
   logic [34:0] exp_q [$];     // expected {off, dout} of each write, in order
   logic [31:0] lsr_q [$];     // scripted LSR values, then lsr_default
   logic [31:0] lsr_default;
   int          ack_delay;
   int          mcount;        // model of bytes buffered
   logic        exp_ovf;
   int          n_reads;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
      end
   endtask

   // MiniUART slave model: acks after ack_delay cycles, checks every write
   initial begin : responder
      int          wcnt;
      logic        prev_ack, pend_pop, cap_valid;
      logic [35:0] cap;
      logic [34:0] e;
      wcnt = 0; prev_ack = 0; pend_pop = 0; cap_valid = 0; cap = '0;
      bus.wb_ack = 1'b0;
      bus.wb_din = 32'd0;
      forever begin
         @(posedge clk); #1;
         bus.wb_ack = 1'b0;
         if (rst) begin
            wcnt = 0; prev_ack = 0; pend_pop = 0; cap_valid = 0;
         end else begin
            if (pend_pop) begin
               mcount--;
               pend_pop = 0;
            end
            chk("fifo_count", 64'(bus.fifo_count), 64'(mcount));
            if (prev_ack) chk("gap_stb", 64'(bus.wb_stb), 64'd0);
            prev_ack = 0;
            if (bus.wb_stb) begin
               if (cap_valid) chk("hold", 64'({bus.wb_we, bus.wb_off, bus.wb_dout}), 64'(cap));
               else begin
                  cap = {bus.wb_we, bus.wb_off, bus.wb_dout};
                  cap_valid = 1;
               end
               if (wcnt >= ack_delay) begin
                  bus.wb_ack = 1'b1;
                  prev_ack = 1; wcnt = 0; cap_valid = 0;
                  if (bus.wb_we) begin
                     if (exp_q.size() == 0) chk("unexpected_write", 64'(exp_q.size()), 64'd1);
                     else begin
                        e = exp_q.pop_front();
                        chk("write", 64'({bus.wb_off, bus.wb_dout}), 64'(e));
                     end
                     if (bus.wb_off == UART_OFF_DATA) pend_pop = 1;
                  end else begin
                     chk("read_off", 64'(bus.wb_off), 64'(UART_OFF_LSR));
                     n_reads++;
                     bus.wb_din = (lsr_q.size() != 0) ? lsr_q.pop_front() : lsr_default;
                  end
               end else wcnt++;
            end else begin
               wcnt = 0;
               cap_valid = 0;
            end
         end
      end
   end

   task automatic push_byte(input logic [7:0] d);
      logic exp_rdy;
      @(negedge clk);
      bus.push_valid = 1'b1;
      bus.push_data  = d;
      exp_rdy = (mcount < DEPTH);
      chk("push_ready", 64'(bus.push_ready), 64'(exp_rdy));
      @(posedge clk);
      if (exp_rdy) begin
         mcount++;
         exp_q.push_back({UART_OFF_DATA, 24'd0, d});
      end else exp_ovf = 1'b1;
      #1 bus.push_valid = 1'b0;
      chk("overflow", 64'(bus.overflow), 64'(exp_ovf));
   endtask

   task automatic wait_idle(input int maxc);
      for (int i = 0; i < maxc; i++) begin
         @(posedge clk); #2;
         if (!bus.busy) break;
      end
      chk("idle_reached", 64'(bus.busy), 64'd0);
   endtask

   initial begin : main
      logic found;
      bus.push_valid = 1'b0;
      bus.push_data  = 8'd0;
      ack_delay = 0; lsr_default = 32'h20; mcount = 0; exp_ovf = 1'b0; n_reads = 0;

      // reset state
      repeat (3) @(posedge clk);
      #2;
      chk("rst_stb",   64'(bus.wb_stb),     64'd0);
      chk("rst_we",    64'(bus.wb_we),      64'd0);
      chk("rst_off",   64'(bus.wb_off),     64'd0);
      chk("rst_dout",  64'(bus.wb_dout),    64'd0);
      chk("rst_count", 64'(bus.fifo_count), 64'd0);
      chk("rst_ready", 64'(bus.push_ready), 64'd1);
      chk("rst_ovf",   64'(bus.overflow),   64'd0);
      chk("rst_busy",  64'(bus.busy),       64'd1);

      // 1: divisor write after release
      exp_q.push_back({UART_OFF_DIVT, 32'd9});
      @(negedge clk) rst = 1'b0;
      wait_idle(50);
      chk("t1_divt_done", 64'(exp_q.size()), 64'd0);

      // 2: single byte, transmitter ready at once
      n_reads = 0;
      push_byte(8'h12);
      wait_idle(100);
      chk("t2_reads", 64'(n_reads), 64'd1);
      chk("t2_drained", 64'(exp_q.size()), 64'd0);

      // 3: transmitter busy for three polls
      n_reads = 0;
      lsr_q.push_back(32'h0); lsr_q.push_back(32'h0); lsr_q.push_back(32'h0);
      push_byte(8'h55);
      wait_idle(100);
      chk("t3_reads", 64'(n_reads), 64'd4);
      chk("t3_drained", 64'(exp_q.size()), 64'd0);

      // 4: fill past full while the transmitter stays busy
      lsr_default = 32'h0;
      for (int i = 0; i < 17; i++) push_byte(8'(i));
      chk("t4_count", 64'(bus.fifo_count), 64'd16);
      chk("t4_ready", 64'(bus.push_ready), 64'd0);
      chk("t4_ovf",   64'(bus.overflow),   64'd1);
      lsr_default = 32'h20;
      wait_idle(3000);
      chk("t4_drained", 64'(exp_q.size()), 64'd0);

      // 5: slow acknowledge on every transaction
      ack_delay = 3;
      push_byte(8'hA1); push_byte(8'hB2); push_byte(8'hC3);
      wait_idle(500);
      chk("t5_drained", 64'(exp_q.size()), 64'd0);

      // 6: reset during a DATA strobe with three bytes buffered
      push_byte(8'h31); push_byte(8'h32); push_byte(8'h33);
      found = 1'b0;
      for (int i = 0; i < 200; i++) begin
         @(posedge clk); #2;
         if (bus.wb_stb && bus.wb_we && bus.wb_off == UART_OFF_DATA) begin
            found = 1'b1;
            break;
         end
      end
      chk("t6_send_seen", 64'(found), 64'd1);
      chk("t6_count_pre", 64'(bus.fifo_count), 64'd3);
      rst = 1'b1;
      exp_q.delete();
      lsr_q.delete();
      mcount = 0;
      exp_ovf = 1'b0;
      exp_q.push_back({UART_OFF_DIVT, 32'd9});
      #1;
      chk("t6_stb",   64'(bus.wb_stb),     64'd0);
      chk("t6_count", 64'(bus.fifo_count), 64'd0);
      chk("t6_ovf",   64'(bus.overflow),   64'd0);
      chk("t6_ready", 64'(bus.push_ready), 64'd1);
      repeat (2) @(posedge clk);
      ack_delay = 0;
      @(negedge clk) rst = 1'b0;
      wait_idle(50);
      chk("t6_divt_done", 64'(exp_q.size()), 64'd0);

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end
endmodule
`default_nettype wire

// File: doc/uart_tx_feeder.md
Name: uart_tx_feeder

Overview:
Upstream companion of the MiniUART. The CPU-side producer pushes bytes into a local FIFO. The block then acts as WISHBONE master on the MiniUART register port and drains that FIFO without CPU involvement. After reset it programs the transmit divisor once, then for each byte it polls LSR until the transmitter is ready and writes the byte to DATA.

Parameters:
DEPTH, 16, FIFO depth in bytes (power of two)
AW, 4, log2(DEPTH)
OFF_DATA, 3'd0, MiniUART DATA register word offset
OFF_LSR, 3'd1, MiniUART LSR word offset
OFF_DIVT, 3'd4, MiniUART transmit-divisor word offset
DIVT_INIT, 32'd9, divisor written after reset (9600 baud)
THRE_BIT, 5, LSR bit meaning "transmitter ready"

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous, active-high reset
push_valid  in  1  producer offers push_data this cycle
push_data  in  8  byte to transmit
push_ready  out  1  FIFO not full; a push is accepted when push_valid & push_ready at a rising edge
overflow  out  1  sticky; set when push_valid & !push_ready
fifo_count  out  AW+1  bytes currently buffered
busy  out  1  FSM not in IDLE, or FIFO non-empty
wb_off  out  3  register offset (MiniUART off[4:2])
wb_dout  out  32  write data to MiniUART din
wb_din  in  32  read data from MiniUART dout
wb_stb  out  1  strobe
wb_we  out  1  write enable
wb_ack  in  1  MiniUART acknowledge

Behaviour:
- Reset (async, immediate):
  - wb_stb=0, wb_we=0, wb_off=0, wb_dout=0.
  - FIFO emptied, so fifo_count=0 and push_ready=1.
  - overflow=0, busy=1, FSM=INIT_DIV.
- Master outputs are registered. Each transaction holds stb, we, off and dout stable until wb_ack is sampled high at a rising edge. stb drops at that same edge.
- At least one idle cycle (stb=0) separates consecutive transactions.
- wb_ack is ignored while stb=0. There is no timeout: the block waits indefinitely.
- FSM states:
  - INIT_DIV: stb=1, we=1, off=OFF_DIVT, dout=DIVT_INIT. On ack go to GAP, then IDLE.
  - IDLE: stb=0. If fifo_count!=0, go to POLL next edge.
  - POLL: stb=1, we=0, off=OFF_LSR. On ack, sample wb_din[THRE_BIT].
    - Bit =1: go to GAP, then SEND.
    - Bit =0: go to GAP, then POLL again.
  - SEND: stb=1, we=1, off=OFF_DATA, dout={24'b0, FIFO head}. On ack, pop the FIFO and go to GAP, then IDLE.
  - GAP: stb=0 for one cycle. It records the successor state.
- Latency: for a push into an empty, idle block accepted at edge E0, the LSR read strobe is high from E1. With single-cycle ack and THRE=1, the DATA write strobe is high from E3 and the pop happens at E4.
- FIFO:
  - Pointers wrap modulo DEPTH. fifo_count ranges 0..DEPTH.
  - Push and pop at the same edge: count unchanged and both take effect. This is only possible when not full, since push_ready=0 when full.
  - Push while full: data dropped, overflow set and held until reset.
  - Bytes are sent in strict FIFO order. The head is only popped on DATA ack.
- The FIFO may receive pushes in any FSM state, including INIT_DIV. Sending starts only after the divisor write completes.
- Reset mid-transaction: stb drops immediately and buffered bytes are lost. After release the divisor is rewritten before any data.
- wb_dout upper 24 bits are always 0 for DATA writes.

Decomposition:
- Shared package (uart_pkg):
  - OFF_DATA/OFF_LSR/OFF_DIVT constants, BAUD_SND_9600 value, THRE bit index.
  - FSM state encoding: INIT_DIV, IDLE, POLL, SEND, GAP.
- One sub-module: uart_tx_fifo. It is a synchronous FIFO: clk/rst, push/pop, 8-bit data, count, full/empty, with async reset.
- The top contains the FSM and the WISHBONE output registers only.

Test Plan:
1. Release reset, ack each strobe after 1 cycle -> first transaction is stb=1, we=1, off=4, dout=0x00000009. stb is low for ≥1 cycle after ack. FSM reaches IDLE, busy=0.
2. Push 0x12, LSR returns 0x20 -> one read with off=1, we=0, then one write with off=0, dout=0x00000012. fifo_count goes 1->0 at the write ack.
3. Push 0x55, LSR returns 0x00 three times then 0x20 -> exactly 4 LSR reads, each separated by one stb=0 cycle, then one DATA write with dout=0x55.
4. Hold LSR=0x00 and push 17 bytes 0x00..0x10 -> push_ready low after the 16th, fifo_count=16, overflow=1. Then set LSR=0x20 -> DATA writes are 0x00..0x0F in order and 0x10 is never sent.
5. Delay ack by 3 cycles on every transaction -> stb, we, off and dout stay constant across the wait. Exactly one pop per DATA ack.
6. Assert rst during a SEND strobe with 3 bytes buffered -> stb=0 immediately, fifo_count=0, overflow=0. After release the first transaction is the DIVT write with dout=9.
